// File: rtl/config_pkg.sv
// config_pkg: shared types and encodings for the branch resolve unit.
// Provides control-flow kinds, FU operation codes, operand/prediction/exception
// records and the resolve record used for redirects and predictor updates.
package config_pkg;
  localparam int ADDR_W = 64;
  localparam logic [ADDR_W-1:0] INSTR_ADDR_MISALIGNED = '0;
  typedef enum logic [2:0] {NoCF, Branch, Jump, JumpR, Return} cf_t;
  typedef enum logic [3:0] {ADD, EQ, NE, LTS, GES, LTU, GEU, JAL, JALR} fu_op_t;
  typedef struct packed {
    fu_op_t            operation;
    logic [ADDR_W-1:0] operand_a;
    logic [ADDR_W-1:0] imm;
  } fu_data_t;
  typedef struct packed {
    cf_t               cf;
    logic [ADDR_W-1:0] predict_address;
  } branchpredict_sbe_t;
  typedef struct packed {
    logic [ADDR_W-1:0] cause;
    logic [ADDR_W-1:0] tval;
    logic              valid;
  } exception_t;
  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] target_address;
    logic              is_mispredict;
    logic              is_taken;
    cf_t               cf_type;
  } bp_resolve_t;
endpackage

// File: rtl/branch_resolve_unit_if.sv
// branch_resolve_unit_if: issue, result and predictor-update bundle.
// slave  = the resolve unit (takes lane issue, drives results and update stream)
// master = the issuing pipeline (drives lanes and upd_ready_i)
interface branch_resolve_unit_if #(
  parameter int NR_LANES = 2,
  parameter int VLEN     = 64
) ();
  import config_pkg::*;
  logic [NR_LANES-1:0] branch_valid_i;
  logic                branch_ready_o;
  logic [VLEN-1:0]     pc_i [NR_LANES];
  fu_data_t            fu_data_i [NR_LANES];
  logic [NR_LANES-1:0] is_compressed_i;
  logic [NR_LANES-1:0] branch_comp_res_i;
  branchpredict_sbe_t  branch_predict_i [NR_LANES];
  logic [NR_LANES-1:0] wb_valid_o;
  logic [VLEN-1:0]     branch_rd_o [NR_LANES];
  exception_t          branch_exception_o [NR_LANES];
  logic                mispredict_o;
  bp_resolve_t         resolved_branch_o;
  logic                upd_valid_o;
  logic                upd_ready_i;
  bp_resolve_t         upd_o;
  modport slave (
    input  branch_valid_i, pc_i, fu_data_i, is_compressed_i, branch_comp_res_i,
           branch_predict_i, upd_ready_i,
    output branch_ready_o, wb_valid_o, branch_rd_o, branch_exception_o,
           mispredict_o, resolved_branch_o, upd_valid_o, upd_o
  );
  modport master (
    output branch_valid_i, pc_i, fu_data_i, is_compressed_i, branch_comp_res_i,
           branch_predict_i, upd_ready_i,
    input  branch_ready_o, wb_valid_o, branch_rd_o, branch_exception_o,
           mispredict_o, resolved_branch_o, upd_valid_o, upd_o
  );
endinterface

// File: rtl/branch_upd_fifo.sv
// branch_upd_fifo: multi-push, single-pop predictor-update queue.
// Ports: clk_i/rst_ni (sync active-low), flush_i empties the queue,
// push_i/data_i up to NR_LANES entries per cycle stored in lane order,
// pop_i dequeues the head, valid_o/data_o present the head,
// ready_o says the registered free count can absorb a full lane group.
module branch_upd_fifo
  import config_pkg::*;
#(
  parameter int NR_LANES = 2,
  parameter int Q_DEPTH  = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic [NR_LANES-1:0] push_i,
  input  bp_resolve_t         data_i [NR_LANES],
  input  logic                pop_i,
  output logic                valid_o,
  output bp_resolve_t         data_o,
  output logic                ready_o
);
  localparam int PW = $clog2(Q_DEPTH);
  localparam int CW = PW + 1;
  bp_resolve_t     mem_q [Q_DEPTH];
  bp_resolve_t     mem_d [Q_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d, n;
  logic            pop;
  assign valid_o = count_q != '0;
  assign data_o  = mem_q[rd_ptr_q];
  // Pops in the same cycle are deliberately not credited to keep ready_o a flop-only path.
  assign ready_o = (CW'(Q_DEPTH) - count_q) >= CW'(NR_LANES);
  assign pop     = valid_o && pop_i;
  always_comb begin
    mem_d = mem_q;
    n     = '0;
    // Pushing lanes are packed into consecutive slots, oldest lane first.
    for (int l = 0; l < NR_LANES; l++) begin
      if (push_i[l]) begin
        mem_d[wr_ptr_q + n[PW-1:0]] = data_i[l];
        n = n + 1'b1;
      end
    end
    wr_ptr_d = flush_i ? '0 : wr_ptr_q + n[PW-1:0];
    rd_ptr_d = flush_i ? '0 : rd_ptr_q + PW'(pop);
    count_d  = flush_i ? '0 : count_q + n - CW'(pop);
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: resolves NR_LANES branches/jumps per cycle.
// Ports: clk_i, rst_ni (sync active-low), flush_i kills all in-flight state,
// bus (slave): lane issue in, registered per-lane results, a single redirect
// record for the oldest mispredict, and the predictor-update stream.
module branch_resolve_unit
  import config_pkg::*;
#(
  parameter int NR_LANES = 2,
  parameter int Q_DEPTH  = 4,
  parameter bit RVC      = 1'b1,
  parameter int VLEN     = 64
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  input logic                  flush_i,
  branch_resolve_unit_if.slave bus
);
  logic [VLEN-1:0]     tgt [NR_LANES];
  logic [VLEN-1:0]     nxt [NR_LANES];
  cf_t                 cf [NR_LANES];
  bp_resolve_t         upd_data [NR_LANES];
  logic [NR_LANES-1:0] jal, jalr, taken, misp, exc, live, push;
  logic                hit, ready;
  logic [NR_LANES-1:0] wb_valid_q, wb_valid_d;
  logic [VLEN-1:0]     rd_q [NR_LANES];
  logic [VLEN-1:0]     rd_d [NR_LANES];
  exception_t          exc_q [NR_LANES];
  exception_t          exc_d [NR_LANES];
  logic                mispredict_q, mispredict_d;
  bp_resolve_t         resolved_q, resolved_d;
  always_comb begin
    hit          = 1'b0;
    mispredict_d = 1'b0;
    resolved_d   = '0;
    for (int l = 0; l < NR_LANES; l++) begin
      jalr[l]  = bus.fu_data_i[l].operation == JALR;
      jal[l]   = bus.fu_data_i[l].operation == JAL;
      nxt[l]   = bus.pc_i[l] + (bus.is_compressed_i[l] ? VLEN'(2) : VLEN'(4));
      tgt[l]   = jalr[l] ? (bus.fu_data_i[l].operand_a + bus.fu_data_i[l].imm) & ~VLEN'(1)
                         : bus.pc_i[l] + bus.fu_data_i[l].imm;
      taken[l] = jal[l] | jalr[l] | bus.branch_comp_res_i[l];
      cf[l]    = jalr[l] ? (bus.branch_predict_i[l].cf == Return ? Return : JumpR)
                         : jal[l] ? Jump : Branch;
      exc[l]   = !RVC && taken[l] && tgt[l][1];
      // JAL targets are fixed at decode, so only JALR and conditional branches can mispredict.
      misp[l]  = !exc[l] && (jalr[l] ? (bus.branch_predict_i[l].cf == NoCF ||
                                        tgt[l] != bus.branch_predict_i[l].predict_address)
                           : !jal[l] && ((taken[l] != (bus.branch_predict_i[l].cf == Branch)) ||
                                         (taken[l] && tgt[l] != bus.branch_predict_i[l].predict_address)));
      // Everything younger than the first redirecting or faulting lane is squashed.
      live[l]  = bus.branch_valid_i[l] && ready && !flush_i && !hit;
      push[l]  = live[l] && !exc[l];
      upd_data[l] = '{valid: 1'b1, pc: bus.pc_i[l], target_address: taken[l] ? tgt[l] : nxt[l],
                      is_mispredict: misp[l], is_taken: taken[l], cf_type: cf[l]};
      wb_valid_d[l] = live[l];
      rd_d[l]       = live[l] ? nxt[l] : '0;
      if (live[l] && exc[l]) exc_d[l] = '{cause: INSTR_ADDR_MISALIGNED, tval: tgt[l], valid: 1'b1};
      else exc_d[l] = '0;
      if (live[l] && misp[l]) begin
        mispredict_d = 1'b1;
        resolved_d   = upd_data[l];
      end
      hit = hit || (live[l] && (misp[l] || exc[l]));
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wb_valid_q   <= '0;
      rd_q         <= '{default: '0};
      exc_q        <= '{default: '0};
      mispredict_q <= 1'b0;
      resolved_q   <= '0;
    end else begin
      wb_valid_q   <= wb_valid_d;
      rd_q         <= rd_d;
      exc_q        <= exc_d;
      mispredict_q <= mispredict_d;
      resolved_q   <= resolved_d;
    end
  end
  branch_upd_fifo #(
    .NR_LANES(NR_LANES),
    .Q_DEPTH (Q_DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .flush_i(flush_i),
    .push_i (push),
    .data_i (upd_data),
    .pop_i  (bus.upd_ready_i),
    .valid_o(bus.upd_valid_o),
    .data_o (bus.upd_o),
    .ready_o(ready)
  );
  assign bus.branch_ready_o     = ready;
  assign bus.wb_valid_o         = wb_valid_q;
  assign bus.branch_rd_o        = rd_q;
  assign bus.branch_exception_o = exc_q;
  assign bus.mispredict_o       = mispredict_q;
  assign bus.resolved_branch_o  = resolved_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed vector table plus multi-cycle sequences for branch_resolve_unit.
module tb_branch_resolve_unit;
  import config_pkg::*;
  typedef struct packed {
    logic        v;
    fu_op_t      op;
    logic [63:0] pc;
    logic [63:0] a;
    logic [63:0] imm;
    logic        c;
    logic        res;
    cf_t         pcf;
    logic [63:0] pa;
  } lane_t;
  typedef struct {
    lane_t       l0;
    lane_t       l1;
    int          wbv;
    int          misp;
    logic [63:0] rtgt;
    int          rtaken;
    cf_t         rcf;
    logic [63:0] rd0;
    int          exc0;
    logic [63:0] tval0;
    int          exc1;
    int          cnt;
  } vec_t;
  localparam lane_t NL = '0;
  localparam int NV = 10;
  logic clk = 1'b0;
  logic rst_n, flush;
  int n_chk = 0;
  int n_err = 0;
  vec_t vecs [NV];
  always #5 clk = ~clk;
  branch_resolve_unit_if #(.NR_LANES(2), .VLEN(64)) bus ();
  branch_resolve_unit #(.NR_LANES(2), .Q_DEPTH(4), .RVC(1'b0), .VLEN(64)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .flush_i(flush),
    .bus    (bus)
  );
  function automatic lane_t ln(fu_op_t op, logic [63:0] pc, logic [63:0] a, logic [63:0] imm,
                               int c, int res, cf_t pcf, logic [63:0] pa);
    ln = '{1'b1, op, pc, a, imm, c != 0, res != 0, pcf, pa};
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic drive(input int l, input lane_t x);
    bus.branch_valid_i[l]    = x.v;
    bus.pc_i[l]              = x.pc;
    bus.fu_data_i[l]         = '{operation: x.op, operand_a: x.a, imm: x.imm};
    bus.is_compressed_i[l]   = x.c;
    bus.branch_comp_res_i[l] = x.res;
    bus.branch_predict_i[l]  = '{cf: x.pcf, predict_address: x.pa};
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drain();
    bus.upd_ready_i = 1'b1;
    for (int k = 0; k < 8 && bus.upd_valid_o; k++) tick();
    chk("drain_empty", 64'(bus.upd_valid_o), 64'h0);
    bus.upd_ready_i = 1'b0;
  endtask
  initial begin
    vecs[0] = '{ln(EQ, 64'h1000, 64'h0, 64'h40, 0, 1, NoCF, 64'h0), NL,
                'b01, 1, 64'h1040, 1, Branch, 64'h1004, 0, 64'h0, 0, 1};
    vecs[1] = '{ln(NE, 64'h1100, 64'h0, 64'h20, 0, 1, Branch, 64'h1120),
                ln(EQ, 64'h1104, 64'h0, 64'hFFFF_FFFF_FFFF_FFF8, 0, 0, NoCF, 64'h0),
                'b11, 0, 64'h0, 0, NoCF, 64'h1104, 0, 64'h0, 0, 2};
    vecs[2] = '{ln(EQ, 64'h2000, 64'h0, 64'h10, 0, 1, NoCF, 64'h0),
                ln(EQ, 64'h2004, 64'h0, 64'h10, 0, 1, NoCF, 64'h0),
                'b01, 1, 64'h2010, 1, Branch, 64'h2004, 0, 64'h0, 0, 1};
    vecs[3] = '{ln(JALR, 64'h2100, 64'h2002, 64'h0, 0, 0, JumpR, 64'h2002),
                ln(EQ, 64'h2104, 64'h0, 64'h8, 0, 0, NoCF, 64'h0),
                'b01, 0, 64'h0, 0, NoCF, 64'h2104, 1, 64'h2002, 0, 0};
    vecs[4] = '{ln(JAL, 64'h3000, 64'h0, 64'h100, 1, 0, Jump, 64'h3100), NL,
                'b01, 0, 64'h0, 0, NoCF, 64'h3002, 0, 64'h0, 0, 1};
    vecs[5] = '{ln(JALR, 64'h4000, 64'h5001, 64'h3, 0, 0, NoCF, 64'h0), NL,
                'b01, 1, 64'h5004, 1, JumpR, 64'h4004, 0, 64'h0, 0, 1};
    vecs[6] = '{ln(JALR, 64'h4100, 64'h6000, 64'h0, 0, 0, Return, 64'h6000),
                ln(EQ, 64'h4104, 64'h0, 64'h40, 0, 1, Branch, 64'h4200),
                'b11, 1, 64'h4144, 1, Branch, 64'h4104, 0, 64'h0, 0, 2};
    vecs[7] = '{ln(EQ, 64'h5000, 64'h0, 64'h80, 0, 0, Branch, 64'h5080), NL,
                'b01, 1, 64'h5004, 0, Branch, 64'h5004, 0, 64'h0, 0, 1};
    vecs[8] = '{ln(JALR, 64'h6000, 64'h7000, 64'h10, 0, 0, Return, 64'h7000), NL,
                'b01, 1, 64'h7010, 1, Return, 64'h6004, 0, 64'h0, 0, 1};
    vecs[9] = '{ln(EQ, 64'h7000, 64'h0, 64'h4, 0, 0, NoCF, 64'h0),
                ln(JAL, 64'h7004, 64'h0, 64'h6, 0, 0, Jump, 64'h700A),
                'b11, 0, 64'h0, 0, NoCF, 64'h7004, 0, 64'h0, 1, 1};
    rst_n = 1'b0;
    flush = 1'b0;
    bus.upd_ready_i = 1'b0;
    drive(0, NL);
    drive(1, NL);
    repeat (2) tick();
    chk("rst_misp", 64'(bus.mispredict_o), 64'h0);
    chk("rst_upd_valid", 64'(bus.upd_valid_o), 64'h0);
    chk("rst_wb_valid", 64'(bus.wb_valid_o), 64'h0);
    chk("rst_count", 64'(dut.u_fifo.count_q), 64'h0);
    rst_n = 1'b1;
    tick();
    chk("rst_ready", 64'(bus.branch_ready_o), 64'h1);
    for (int i = 0; i < NV; i++) begin
      drive(0, vecs[i].l0);
      drive(1, vecs[i].l1);
      tick();
      drive(0, NL);
      drive(1, NL);
      chk($sformatf("v%0d_wb_valid", i), 64'(bus.wb_valid_o), 64'(vecs[i].wbv));
      chk($sformatf("v%0d_misp", i), 64'(bus.mispredict_o), 64'(vecs[i].misp));
      chk($sformatf("v%0d_target", i), bus.resolved_branch_o.target_address, vecs[i].rtgt);
      chk($sformatf("v%0d_taken", i), 64'(bus.resolved_branch_o.is_taken), 64'(vecs[i].rtaken));
      chk($sformatf("v%0d_cf", i), 64'(bus.resolved_branch_o.cf_type), 64'(vecs[i].rcf));
      chk($sformatf("v%0d_rd0", i), bus.branch_rd_o[0], vecs[i].rd0);
      chk($sformatf("v%0d_exc0", i), 64'(bus.branch_exception_o[0].valid), 64'(vecs[i].exc0));
      chk($sformatf("v%0d_tval0", i), bus.branch_exception_o[0].tval, vecs[i].tval0);
      chk($sformatf("v%0d_exc1", i), 64'(bus.branch_exception_o[1].valid), 64'(vecs[i].exc1));
      chk($sformatf("v%0d_pushes", i), 64'(dut.u_fifo.count_q), 64'(vecs[i].cnt));
      tick();
      chk($sformatf("v%0d_misp_pulse", i), 64'(bus.mispredict_o), 64'h0);
      drain();
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, ln(EQ, 64'h8000 + 64'(4 * i), 64'h0, 64'h10, 0, 0, NoCF, 64'h0));
      tick();
      chk($sformatf("full%0d_count", i), 64'(dut.u_fifo.count_q), 64'(i < 3 ? i + 1 : 3));
      chk($sformatf("full%0d_ready", i), 64'(bus.branch_ready_o), 64'(i < 2));
      chk($sformatf("full%0d_wb", i), 64'(bus.wb_valid_o[0]), 64'(i < 3));
    end
    drive(0, NL);
    bus.upd_ready_i = 1'b1;
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("pop%0d_valid", j), 64'(bus.upd_valid_o), 64'h1);
      chk($sformatf("pop%0d_pc", j), bus.upd_o.pc, 64'h8000 + 64'(4 * j));
      tick();
      chk($sformatf("pop%0d_count", j), 64'(dut.u_fifo.count_q), 64'(2 - j));
      chk($sformatf("pop%0d_ready", j), 64'(bus.branch_ready_o), 64'h1);
    end
    chk("pop_empty", 64'(bus.upd_valid_o), 64'h0);
    bus.upd_ready_i = 1'b0;
    drive(0, ln(EQ, 64'h9000, 64'h0, 64'h10, 0, 0, NoCF, 64'h0));
    tick();
    bus.upd_ready_i = 1'b1;
    drive(0, ln(EQ, 64'h9004, 64'h0, 64'h10, 0, 0, NoCF, 64'h0));
    tick();
    bus.upd_ready_i = 1'b0;
    chk("pushpop_count", 64'(dut.u_fifo.count_q), 64'h1);
    chk("pushpop_head", bus.upd_o.pc, 64'h9004);
    drive(0, ln(EQ, 64'h9008, 64'h0, 64'h10, 0, 0, NoCF, 64'h0));
    drive(1, ln(EQ, 64'h900C, 64'h0, 64'h10, 0, 0, NoCF, 64'h0));
    tick();
    chk("preflush_count", 64'(dut.u_fifo.count_q), 64'h3);
    drive(0, ln(EQ, 64'h9100, 64'h0, 64'h40, 0, 1, NoCF, 64'h0));
    drive(1, NL);
    bus.upd_ready_i = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(0, NL);
    bus.upd_ready_i = 1'b0;
    chk("flush_upd_valid", 64'(bus.upd_valid_o), 64'h0);
    chk("flush_count", 64'(dut.u_fifo.count_q), 64'h0);
    chk("flush_misp", 64'(bus.mispredict_o), 64'h0);
    chk("flush_wb", 64'(bus.wb_valid_o), 64'h0);
    chk("flush_ready", 64'(bus.branch_ready_o), 64'h1);
    drive(0, ln(EQ, 64'hA000, 64'h0, 64'h10, 0, 0, NoCF, 64'h0));
    drive(1, ln(EQ, 64'hA004, 64'h0, 64'h10, 0, 0, NoCF, 64'h0));
    tick();
    chk("prerst_count", 64'(dut.u_fifo.count_q), 64'h2);
    drive(0, ln(EQ, 64'hA100, 64'h0, 64'h40, 0, 1, NoCF, 64'h0));
    drive(1, NL);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    drive(0, NL);
    chk("midrst_misp", 64'(bus.mispredict_o), 64'h0);
    chk("midrst_wb", 64'(bus.wb_valid_o), 64'h0);
    chk("midrst_count", 64'(dut.u_fifo.count_q), 64'h0);
    chk("midrst_upd_valid", 64'(bus.upd_valid_o), 64'h0);
    chk("midrst_target", bus.resolved_branch_o.target_address, 64'h0);
    chk("midrst_ready", 64'(bus.branch_ready_o), 64'h1);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end
endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have parameter NR_LANES, default 2, number of parallel branch lanes; lane 0 is oldest in any cycle.
REQ-002 SHALL have parameter Q_DEPTH, default 4, predictor-update FIFO entries (power of two, >= NR_LANES).
REQ-003 SHALL have parameter RVC, default 1, compressed ISA enabled; 0 enables 4-byte target alignment checking.
REQ-004 SHALL have parameter VLEN, default 64, virtual address width.
REQ-005 SHALL have port clk_i  in  1  sole clock; every register updates on its rising edge.
REQ-006 SHALL have port rst_ni  in  1  reset, synchronous, active-low.
REQ-007 SHALL have port flush_i  in  1  kill all in-flight state.
REQ-008 SHALL have ports branch_valid_i  in  NR_LANES  lane issue valid; branch_ready_o  out  1  all lanes may issue.
REQ-009 SHALL have per-lane inputs pc_i (VLEN), fu_data_i (fu_data_t), is_compressed_i (1), branch_comp_res_i (1), branch_predict_i (branchpredict_sbe_t).
REQ-010 SHALL have per-lane outputs wb_valid_o (1), branch_rd_o (VLEN, link value), branch_exception_o (exception_t).
REQ-011 SHALL have ports mispredict_o  out  1; resolved_branch_o  out  bp_resolve_t  redirect record.
REQ-012 SHALL have ports upd_valid_o  out  1; upd_ready_i  in  1; upd_o  out  bp_resolve_t  predictor-update stream.

Function
REQ-013 SHALL compute target = operand_a + sign-extended imm for JALR (bit 0 cleared) and pc + imm for JAL and conditional branches.
REQ-014 SHALL compute link/next PC = pc + 2 if is_compressed_i, else pc + 4, modulo 2^VLEN.
REQ-015 SHALL take a conditional branch when branch_comp_res_i=1; JAL and JALR are always taken.
REQ-016 SHALL flag a conditional-branch mispredict when taken differs from (predicted cf == Branch), or when taken and target != predict_address.
REQ-017 SHALL flag a JALR mispredict when predicted cf == NoCF or target != predict_address; cf_type = JumpR unless predicted Return.
REQ-018 SHALL, when RVC=0 and the lane is taken with target[1]=1, raise INSTR_ADDR_MISALIGNED with tval = target; that lane then reports no mispredict and is not enqueued.
REQ-019 SHALL register all results; lane outputs and mispredict_o are valid exactly 1 cycle after issue.
REQ-020 SHALL, when several lanes mispredict or except in one cycle, report only the lowest such lane; younger lanes get wb_valid_o=0 and no side effects.
REQ-021 SHALL drive resolved_branch_o with pc, target (taken) or next PC (not taken), is_taken, cf_type, is_mispredict=1 while mispredict_o=1.
REQ-022 SHALL push every valid, non-killed, non-excepting lane into the update FIFO in lane order on the result cycle.
REQ-023 SHALL drive branch_ready_o = 1 iff the registered free-entry count >= NR_LANES; same-cycle pops are not credited.
REQ-024 SHALL pop the FIFO head on upd_valid_o && upd_ready_i; simultaneous push and pop SHALL both take effect.
REQ-025 SHALL wrap read/write pointers modulo Q_DEPTH; occupancy is tracked by a counter of width clog2(Q_DEPTH)+1.
REQ-026 SHALL ignore branch_valid_i on lanes presented while branch_ready_o=0.
REQ-027 SHALL, on flush_i, clear the result stage and FIFO next edge; lanes issued in the flush cycle are dropped; flush_i takes priority over issue and pop.

Reset
REQ-028 SHALL, with rst_ni=0 at a clock edge, clear all valids, the FIFO count and pointers, mispredict_o, and all exception valids; data outputs reset to zero.
REQ-029 SHALL treat reset asserted mid-operation exactly like REQ-028; no in-flight entry survives.
REQ-030 SHALL drive branch_ready_o=1 on the first cycle after reset deassertion.

Structure
REQ-031 SHALL take bp_resolve_t, branchpredict_sbe_t, exception_t, fu_data_t, the cf_type enum, the operation encodings and INSTR_ADDR_MISALIGNED from config_pkg.
REQ-032 SHALL instantiate one sub-module, branch_upd_fifo, for the multi-push single-pop update FIFO.

Verification
REQ-033 SHALL test lane0 BEQ pc=0x1000 imm=0x40 taken, predicted NoCF -> next cycle mispredict_o=1, target 0x1040, is_taken=1.
REQ-034 SHALL test lane0 and lane1 both mispredicting -> only lane0 redirect; lane1 wb_valid_o=0; one FIFO push.
REQ-035 SHALL test RVC=0, JALR operand_a=0x2002 imm=0 -> exception valid, tval=0x2002, mispredict_o=0, no push.
REQ-036 SHALL test upd_ready_i=0 with 4 pushes of 1 lane each, Q_DEPTH=4 -> branch_ready_o=0 once free < 2; recovers after pops.
REQ-037 SHALL test flush_i with 3 FIFO entries and a concurrent issue -> next cycle upd_valid_o=0, count 0, no mispredict.
REQ-038 SHALL test compressed JAL pc=0x3000 -> branch_rd_o=0x3002.
